// File: rtl/iic_eeprom_rd.sv
// iic_eeprom_rd: burst-reads NUM_BYTES from the on-board I2C EEPROM through
// one PCA9548 switch-channel request port, retries on failure, and publishes
// the assembled word as DATA_OUT/VALID_OUT.
// Optional feature macro: IIC_EEPROM_RD_CSUM_EN (read and verify a trailing
// checksum byte; the 8-bit sum of all bytes read must be 8'h00).
module iic_eeprom_rd #(
   parameter logic [6:0]  DEV_ADDR   = 7'h54,
   parameter logic [7:0]  WORD_ADDR  = 8'h00,
   parameter int unsigned NUM_BYTES  = 6,
   parameter int unsigned RETRY      = 3,
   parameter int unsigned RETRY_WAIT = 2000
) (
   input  logic                   CLK_IN,
   input  logic                   RESET_IN,
   input  logic                   START_IN,
   output logic                   BUSY_OUT,
   output logic                   VALID_OUT,
   output logic                   FAIL_OUT,
   output logic [8*NUM_BYTES-1:0] DATA_OUT,
   output logic                   IIC_REQ_OUT,
   output logic [7:0]             IIC_NUM_OUT,
   output logic [6:0]             IIC_DAD_OUT,
   output logic [7:0]             IIC_ADR_OUT,
   output logic                   IIC_RNW_OUT,
   output logic [7:0]             IIC_WDT_OUT,
   input  logic                   IIC_RAK_IN,
   input  logic                   IIC_BSY_IN,
   input  logic [7:0]             IIC_RDT_IN,
   input  logic                   IIC_RVL_IN,
   input  logic                   IIC_EOR_IN,
   input  logic                   IIC_ERR_IN
);

`ifdef IIC_EEPROM_RD_CSUM_EN
   localparam int unsigned EXP_BYTES = NUM_BYTES + 1;
`else
   localparam int unsigned EXP_BYTES = NUM_BYTES;
`endif
   localparam int unsigned CNT_W  = 5;
   localparam int unsigned ATT_W  = 4;
   localparam int unsigned WAIT_W = 16;
   localparam int unsigned DW     = 8 * NUM_BYTES;

   typedef enum logic [2:0] {
      S_IDLE, S_REQ, S_RUN, S_CHECK, S_WAIT, S_DONE, S_FAIL
   } state_t;

   state_t              state_q, state_d;
   logic                start_pend_q, start_pend_d;
   logic                busy_q, busy_d;
   logic                valid_q, valid_d;
   logic                fail_q, fail_d;
   logic                req_q, req_d;
   logic [DW-1:0]       data_q, data_d;
   logic [7:0]          shadow_q [EXP_BYTES];
   logic [7:0]          shadow_d [EXP_BYTES];
   logic [CNT_W-1:0]    byte_cnt_q, byte_cnt_d;
   logic                eor_q, eor_d;
   logic                err_q, err_d;
   logic [ATT_W-1:0]    att_q, att_d;
   logic [WAIT_W-1:0]   wait_q, wait_d;
   logic                bsy_q;
   logic                csum_ok_c;
   logic                pass_c;

   // Constant request fields towards the switch channel
   assign IIC_NUM_OUT = 8'(EXP_BYTES - 1);
   assign IIC_DAD_OUT = DEV_ADDR;
   assign IIC_ADR_OUT = WORD_ADDR;
   assign IIC_RNW_OUT = 1'b1;
   assign IIC_WDT_OUT = 8'h00;

   assign BUSY_OUT    = busy_q;
   assign VALID_OUT   = valid_q;
   assign FAIL_OUT    = fail_q;
   assign DATA_OUT    = data_q;
   assign IIC_REQ_OUT = req_q;

`ifdef IIC_EEPROM_RD_CSUM_EN
   logic [7:0] csum_c;

   // Running 8-bit sum over data plus checksum byte
   always_comb begin
      csum_c = 8'h00;
      for (int i = 0; i < EXP_BYTES; i++) csum_c = csum_c + shadow_q[i];
   end
   assign csum_ok_c = (csum_c == 8'h00);
`else
   assign csum_ok_c = 1'b1;
`endif

   // An attempt is good only if it ended cleanly with exactly the expected length
   assign pass_c = !err_q && eor_q && (byte_cnt_q == CNT_W'(EXP_BYTES)) && csum_ok_c;

   // State and datapath registers; reset arms an automatic first read
   always_ff @(posedge CLK_IN) begin
      if (RESET_IN) begin
         state_q      <= S_IDLE;
         start_pend_q <= 1'b1;
         busy_q       <= 1'b0;
         valid_q      <= 1'b0;
         fail_q       <= 1'b0;
         req_q        <= 1'b0;
         data_q       <= '0;
         shadow_q     <= '{default: '0};
         byte_cnt_q   <= '0;
         eor_q        <= 1'b0;
         err_q        <= 1'b0;
         att_q        <= '0;
         wait_q       <= '0;
         bsy_q        <= 1'b0;
      end else begin
         state_q      <= state_d;
         start_pend_q <= start_pend_d;
         busy_q       <= busy_d;
         valid_q      <= valid_d;
         fail_q       <= fail_d;
         req_q        <= req_d;
         data_q       <= data_d;
         shadow_q     <= shadow_d;
         byte_cnt_q   <= byte_cnt_d;
         eor_q        <= eor_d;
         err_q        <= err_d;
         att_q        <= att_d;
         wait_q       <= wait_d;
         bsy_q        <= IIC_BSY_IN;
      end
   end

   // Next-state and output logic; channel BSY is expected high by the RAK cycle
   always_comb begin
      state_d      = state_q;
      start_pend_d = start_pend_q;
      busy_d       = busy_q;
      valid_d      = valid_q;
      fail_d       = fail_q;
      req_d        = req_q;
      data_d       = data_q;
      shadow_d     = shadow_q;
      byte_cnt_d   = byte_cnt_q;
      eor_d        = eor_q;
      err_d        = err_q;
      att_d        = att_q;
      wait_d       = wait_q;

      case (state_q)
         S_IDLE, S_DONE, S_FAIL: begin
            if (start_pend_q || START_IN) begin
               state_d      = S_REQ;
               start_pend_d = 1'b0;
               valid_d      = 1'b0;
               fail_d       = 1'b0;
               busy_d       = 1'b1;
               att_d        = '0;
               byte_cnt_d   = '0;
               eor_d        = 1'b0;
               err_d        = 1'b0;
            end
         end
         S_REQ: begin
            if (IIC_RAK_IN) begin
               req_d   = 1'b0;
               state_d = S_RUN;
            end else begin
               req_d   = 1'b1;
            end
         end
         S_RUN: begin
            if (IIC_RVL_IN) begin
               for (int i = 0; i < EXP_BYTES; i++) begin
                  if (byte_cnt_q == CNT_W'(i)) shadow_d[i] = IIC_RDT_IN;
               end
               if (byte_cnt_q <= CNT_W'(EXP_BYTES)) byte_cnt_d = byte_cnt_q + CNT_W'(1);
               if (IIC_EOR_IN) eor_d = 1'b1;
            end
            if (IIC_ERR_IN) err_d = 1'b1;
            if (!bsy_q) state_d = S_CHECK;
         end
         S_CHECK: begin
            if (pass_c) begin
               for (int i = 0; i < NUM_BYTES; i++) begin
                  data_d[8*(NUM_BYTES-1-i) +: 8] = shadow_q[i];
               end
               valid_d = 1'b1;
               busy_d  = 1'b0;
               state_d = S_DONE;
            end else if (att_q < ATT_W'(RETRY)) begin
               att_d   = att_q + ATT_W'(1);
               wait_d  = '0;
               state_d = S_WAIT;
            end else begin
               fail_d  = 1'b1;
               busy_d  = 1'b0;
               state_d = S_FAIL;
            end
         end
         S_WAIT: begin
            if (wait_q == WAIT_W'(RETRY_WAIT - 1)) begin
               wait_d     = '0;
               byte_cnt_d = '0;
               eor_d      = 1'b0;
               err_d      = 1'b0;
               state_d    = S_REQ;
            end else begin
               wait_d     = wait_q + WAIT_W'(1);
            end
         end
         default: state_d = S_IDLE;
      endcase
   end

endmodule

// File: tb/tb_iic_eeprom_rd.sv
// Self-checking bench for iic_eeprom_rd: table of read transactions plus
// hand-written sequences for reset timing, START handling and mid-read reset.
// Honours IIC_EEPROM_RD_CSUM_EN (then runs with NUM_BYTES=2).
module tb_iic_eeprom_rd;

`ifdef IIC_EEPROM_RD_CSUM_EN
   localparam int unsigned NB  = 2;
   localparam int unsigned EXP = 3;
`else
   localparam int unsigned NB  = 6;
   localparam int unsigned EXP = 6;
`endif
   localparam int unsigned DW = 8 * NB;
   localparam int unsigned RW = 20;
   localparam int unsigned RT = 3;

   typedef logic [3:0][4:0] lens_t;
   typedef struct {
      int unsigned   n_att;
      logic [3:0]    errs;
      lens_t         lens;
      logic [127:0]  src;
      logic          ev;
      logic          ef;
      logic [DW-1:0] ed;
   } vec_t;

   logic clk = 1'b0;
   logic rst, start, rak, bsy, rvl, eor, err;
   logic [7:0] rdt;
   logic busy, valid, fail, req, rnw;
   logic [DW-1:0] data;
   logic [7:0] num, adr, wdt;
   logic [6:0] dad;

   int checks = 0;
   int errors = 0;
   int cyc = 0;
   int req_rises = 0;
   int bsy_fall_cyc = 0;
   logic req_seen = 1'b0;
   vec_t vecs[6];
   logic [127:0] hs_src;
   logic [DW-1:0] hs_exp;

   iic_eeprom_rd #(
      .DEV_ADDR(7'h54), .WORD_ADDR(8'h00), .NUM_BYTES(NB),
      .RETRY(RT), .RETRY_WAIT(RW)
   ) dut (
      .CLK_IN(clk), .RESET_IN(rst), .START_IN(start),
      .BUSY_OUT(busy), .VALID_OUT(valid), .FAIL_OUT(fail), .DATA_OUT(data),
      .IIC_REQ_OUT(req), .IIC_NUM_OUT(num), .IIC_DAD_OUT(dad),
      .IIC_ADR_OUT(adr), .IIC_RNW_OUT(rnw), .IIC_WDT_OUT(wdt),
      .IIC_RAK_IN(rak), .IIC_BSY_IN(bsy), .IIC_RDT_IN(rdt),
      .IIC_RVL_IN(rvl), .IIC_EOR_IN(eor), .IIC_ERR_IN(err)
   );

   always #5 clk = ~clk;

   always @(posedge clk) cyc <= cyc + 1;

   // Count rising edges of the channel request
   always @(negedge clk) begin
      if (req === 1'b1 && req_seen === 1'b0) req_rises <= req_rises + 1;
      req_seen <= req;
   end

   initial begin
      #500000;
      $display("FAIL watchdog: simulation still running at %0t, expected finish earlier", $time);
      $fatal(1, "watchdog");
   end

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   function automatic lens_t mk_lens(input int a, input int b, input int c, input int d);
      return {5'(d), 5'(c), 5'(b), 5'(a)};
   endfunction

   function automatic vec_t mkv(input int unsigned n, input logic [3:0] e, input lens_t l,
                                input logic [127:0] s, input logic ev, input logic ef,
                                input logic [DW-1:0] ed);
      vec_t v;
      v.n_att = n; v.errs = e; v.lens = l; v.src = s; v.ev = ev; v.ef = ef; v.ed = ed;
      return v;
   endfunction

   task automatic pulse_start();
      start = 1'b1;
      @(negedge clk);
      start = 1'b0;
   endtask

   task automatic wait_req(output bit ok, output int rise_cyc);
      ok = 1'b0;
      rise_cyc = 0;
      for (int t = 0; t < 300; t++) begin
         if (req === 1'b1) begin
            ok = 1'b1;
            rise_cyc = cyc;
            break;
         end
         @(negedge clk);
      end
      if (!ok) begin
         checks++; errors++;
         $display("FAIL req_timeout: IIC_REQ_OUT=%b, expected 1 within 300 cycles", req);
      end
   endtask

   task automatic wait_idle(output bit ok);
      ok = 1'b0;
      for (int t = 0; t < 300; t++) begin
         if (busy === 1'b0) begin
            ok = 1'b1;
            break;
         end
         @(negedge clk);
      end
      if (!ok) begin
         checks++; errors++;
         $display("FAIL busy_timeout: BUSY_OUT=%b, expected 0 within 300 cycles", busy);
      end
   endtask

   // Channel model: acknowledge, optional error, then len bytes with EOR on the last
   task automatic serve(input logic [127:0] src, input int len, input logic with_err,
                        input bit start_mid);
      rak = 1'b1; bsy = 1'b1;
      @(negedge clk);
      rak = 1'b0; err = with_err;
      @(negedge clk);
      err = 1'b0;
      for (int k = 0; k < len; k++) begin
         rvl = 1'b1;
         rdt = src[8*(15-k) +: 8];
         eor = (k == len - 1);
         start = start_mid && (k == 0);
         @(negedge clk);
      end
      rvl = 1'b0; eor = 1'b0; start = 1'b0;
      @(negedge clk);
      bsy = 1'b0;
      bsy_fall_cyc = cyc;
   endtask

   task automatic run_vec(input int vi, input bit do_start, input int base);
      vec_t v;
      bit ok;
      int rc;
      v = vecs[vi];
      if (do_start) pulse_start();
      for (int a = 0; a < int'(v.n_att); a++) begin
         wait_req(ok, rc);
         if (!ok) return;
         if (a > 0) begin
            checks++;
            if (rc - bsy_fall_cyc < int'(RW) + 2) begin
               errors++;
               $display("FAIL v%0d_gap: REQ rose %0d cycles after BSY fall, expected >= %0d",
                        vi, rc - bsy_fall_cyc, RW + 2);
            end
         end
         serve(v.src, int'(v.lens[a]), v.errs[a], 1'b0);
      end
      wait_idle(ok);
      if (!ok) return;
      chk($sformatf("v%0d_valid", vi), 64'(valid), 64'(v.ev));
      chk($sformatf("v%0d_fail", vi), 64'(fail), 64'(v.ef));
      chk($sformatf("v%0d_data", vi), 64'(data), 64'(v.ed));
      chk($sformatf("v%0d_reqs", vi), 64'(req_rises - base), 64'(v.n_att));
   endtask

   initial begin
      bit ok;
      int rc;
      int base;

`ifdef IIC_EEPROM_RD_CSUM_EN
      vecs[0] = mkv(1, 4'b0000, mk_lens(3,3,3,3), {24'h1234BA, 104'h0}, 1'b1, 1'b0, 16'h1234);
      vecs[1] = mkv(4, 4'b0000, mk_lens(3,3,3,3), {24'h1234BB, 104'h0}, 1'b0, 1'b1, 16'h1234);
      vecs[2] = mkv(2, 4'b0001, mk_lens(3,3,3,3), {24'h567832, 104'h0}, 1'b1, 1'b0, 16'h5678);
      vecs[3] = mkv(3, 4'b0000, mk_lens(2,4,3,3), {24'hABCD88, 8'h11, 96'h0}, 1'b1, 1'b0, 16'hABCD);
      vecs[4] = mkv(4, 4'b0000, mk_lens(2,4,4,2), {24'hFF0100, 8'h22, 96'h0}, 1'b0, 1'b1, 16'hABCD);
      vecs[5] = mkv(1, 4'b0000, mk_lens(3,3,3,3), {24'h1001EF, 104'h0}, 1'b1, 1'b0, 16'h1001);
      hs_src  = {24'h2233AB, 104'h0};
      hs_exp  = 16'h2233;
`else
      vecs[0] = mkv(1, 4'b0000, mk_lens(6,6,6,6), {48'h000A35010203, 80'h0}, 1'b1, 1'b0, 48'h000A35010203);
      vecs[1] = mkv(2, 4'b0001, mk_lens(6,6,6,6), {48'h112233445566, 8'h99, 72'h0}, 1'b1, 1'b0, 48'h112233445566);
      vecs[2] = mkv(4, 4'b1111, mk_lens(6,6,6,6), {48'hAABBCCDDEEFF, 80'h0}, 1'b0, 1'b1, 48'h112233445566);
      vecs[3] = mkv(3, 4'b0000, mk_lens(5,7,6,6), {48'h010203040506, 8'h07, 72'h0}, 1'b1, 1'b0, 48'h010203040506);
      vecs[4] = mkv(4, 4'b0000, mk_lens(5,7,7,5), {48'h5A5A5A5A5A5A, 8'hA5, 72'h0}, 1'b0, 1'b1, 48'h010203040506);
      vecs[5] = mkv(1, 4'b0000, mk_lens(6,6,6,6), {48'hC0FFEE123456, 80'h0}, 1'b1, 1'b0, 48'hC0FFEE123456);
      hs_src  = {48'h0A0B0C0D0E0F, 80'h0};
      hs_exp  = 48'h0A0B0C0D0E0F;
`endif

      rst = 1'b1; start = 1'b0; rak = 1'b0; bsy = 1'b0;
      rvl = 1'b0; eor = 1'b0; err = 1'b0; rdt = 8'h00;
      repeat (3) @(negedge clk);

      // Reset state and constant request fields
      chk("rst_busy",  64'(busy),  64'd0);
      chk("rst_valid", 64'(valid), 64'd0);
      chk("rst_fail",  64'(fail),  64'd0);
      chk("rst_req",   64'(req),   64'd0);
      chk("rst_data",  64'(data),  64'd0);
      chk("const_num", 64'(num),   64'(EXP - 1));
      chk("const_dad", 64'(dad),   64'h54);
      chk("const_adr", 64'(adr),   64'h00);
      chk("const_rnw", 64'(rnw),   64'd1);
      chk("const_wdt", 64'(wdt),   64'h00);

      // Auto-start: REQ high on the 2nd edge after release
      base = req_rises;
      rst = 1'b0;
      @(posedge clk); #1;
      chk("auto_edge1_req",  64'(req),  64'd0);
      chk("auto_edge1_busy", 64'(busy), 64'd1);
      @(posedge clk); #1;
      chk("auto_edge2_req",  64'(req),  64'd1);
      @(negedge clk);
      run_vec(0, 1'b0, base);

      for (int i = 1; i < 6; i++) begin
         run_vec(i, 1'b1, req_rises);
         chk($sformatf("v%0d_excl", i), 64'(valid & fail), 64'd0);
      end

      // START during RUN is ignored and not queued
      base = req_rises;
      pulse_start();
      wait_req(ok, rc);
      if (ok) begin
         serve(hs_src, int'(EXP), 1'b0, 1'b1);
         wait_idle(ok);
      end
      chk("startrun_reqs",  64'(req_rises - base), 64'd1);
      chk("startrun_valid", 64'(valid), 64'd1);
      chk("startrun_data",  64'(data),  64'(hs_exp));
      repeat (RW + 20) @(negedge clk);
      chk("startrun_noqueue_reqs", 64'(req_rises - base), 64'd1);
      chk("startrun_noqueue_busy", 64'(busy), 64'd0);

      // START in DONE: VALID drops on the next edge and a new read follows
      base = req_rises;
      start = 1'b1;
      @(posedge clk); #1;
      chk("donestart_valid", 64'(valid), 64'd0);
      chk("donestart_busy",  64'(busy),  64'd1);
      @(negedge clk);
      start = 1'b0;
      wait_req(ok, rc);
      if (ok) begin
         serve(vecs[5].src, int'(EXP), 1'b0, 1'b0);
         wait_idle(ok);
      end
      chk("donestart_reqs", 64'(req_rises - base), 64'd1);
      chk("donestart_data", 64'(data), 64'(vecs[5].ed));

      // Reset in the middle of a transfer, with stray channel data around it
      pulse_start();
      wait_req(ok, rc);
      rak = 1'b1; bsy = 1'b1;
      @(negedge clk);
      rak = 1'b0;
      rvl = 1'b1; rdt = 8'h77;
      @(negedge clk);
      rst = 1'b1; rdt = 8'hEE;
      @(negedge clk);
      @(negedge clk);
      base = req_rises;
      rst = 1'b0; bsy = 1'b0; rdt = 8'hE1;
      chk("midrst_data",  64'(data),  64'd0);
      chk("midrst_valid", 64'(valid), 64'd0);
      @(negedge clk);
      rvl = 1'b0;
      wait_req(ok, rc);
      if (ok) begin
         serve(hs_src, int'(EXP), 1'b0, 1'b0);
         wait_idle(ok);
      end
      chk("midrst_reqs",  64'(req_rises - base), 64'd1);
      chk("midrst_valid2", 64'(valid), 64'd1);
      chk("midrst_data2",  64'(data),  64'(hs_exp));

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule

// File: doc/iic_eeprom_rd.md
# iic_eeprom_rd

Upstream client of the PCA9548 channel switch: after reset (and on each START_IN pulse) it issues one burst read of NUM_BYTES bytes from the on-board I2C EEPROM through one switch channel's request port. It assembles the bytes into a parallel word and retries on bus error. It publishes the result, typically the MAC address and IP defaults, to the SiTCP core as DATA_OUT/VALID_OUT.

## Interface
- DEV_ADDR, 7'h54, EEPROM 7-bit device address
- WORD_ADDR, 8'h00, first word address read
- NUM_BYTES, 6, bytes per read, legal 1..16
- RETRY, 3, extra attempts after a failed attempt, legal 0..15
- RETRY_WAIT, 16'd2000, idle cycles between a failed attempt and the next request, legal ≥1

- CLK_IN  in  1  system clock; single clock domain
- RESET_IN  in  1  reset, synchronous, active-high
- START_IN  in  1  one-cycle pulse requesting a new read
- BUSY_OUT  out  1  high from request until DONE/FAIL
- VALID_OUT  out  1  DATA_OUT holds a good read
- FAIL_OUT  out  1  all attempts exhausted
- DATA_OUT  out  8*NUM_BYTES  byte 0 in MSBs, last byte in LSBs
- IIC_REQ_OUT  out  1  channel request
- IIC_NUM_OUT  out  8  NUM_BYTES-1 (or NUM_BYTES with checksum)
- IIC_DAD_OUT  out  7  DEV_ADDR, constant
- IIC_ADR_OUT  out  8  WORD_ADDR, constant
- IIC_RNW_OUT  out  1  constant 1
- IIC_WDT_OUT  out  8  constant 8'h00
- IIC_RAK_IN  in  1  request acknowledge pulse
- IIC_BSY_IN  in  1  channel busy
- IIC_RDT_IN  in  8  read data
- IIC_RVL_IN  in  1  read data valid
- IIC_EOR_IN  in  1  last read byte, coincident with RVL
- IIC_ERR_IN  in  1  transfer error

## Operation
- States: IDLE, REQ, RUN, CHECK, WAIT, DONE, FAIL.
- Reset: state IDLE with internal start_pend=1. All outputs 0 except the constants. DATA_OUT=0, attempt counter=0.
- IDLE/DONE/FAIL: start_pend or START_IN -> REQ.
  - Clear VALID_OUT and FAIL_OUT, attempt counter=0, byte counter=0, err flag=0.
  - BUSY_OUT=1.
- START_IN while BUSY_OUT=1 is ignored. It is not queued.
- REQ: IIC_REQ_OUT=1, held until IIC_RAK_IN is sampled high.
  - REQ drops the cycle after RAK.
  - State goes to RUN on that same cycle.
- RUN:
  - Each IIC_RVL_IN: IIC_RDT_IN goes into shadow byte[byte_cnt] if byte_cnt < expected; byte_cnt saturates at expected+1.
  - IIC_EOR_IN with RVL sets eor_seen.
  - IIC_ERR_IN sets the err flag.
  - IIC_BSY_IN sampled 0 -> CHECK.
- CHECK (one cycle):
  - Pass iff err=0, eor_seen=1 and byte_cnt==expected (plus checksum if enabled).
  - Pass: DATA_OUT <= shadow, loaded atomically. VALID_OUT=1, BUSY_OUT=0, go to DONE.
  - Fail with attempt counter < RETRY: increment the counter, go to WAIT.
  - Fail with counter exhausted: FAIL_OUT=1, BUSY_OUT=0, go to FAIL. DATA_OUT keeps its previous value.
- WAIT: counts RETRY_WAIT cycles, clears the per-attempt flags and byte counter, then goes to REQ.
- Reset mid-transfer returns to the reset state and auto-starts. Channel data arriving after reset is ignored until the next RUN.

## Timing
- IIC_REQ_OUT rises 1 cycle after entry into REQ. From reset release, REQ_OUT is high on the 2nd clock edge.
- DATA_OUT and VALID_OUT update on the same edge, 2 cycles after IIC_BSY_IN is sampled low.
- FAIL_OUT and BUSY_OUT fall on that same edge on the failing path.
- Between two attempts the minimum REQ-low gap is RETRY_WAIT+2 cycles.
- Total attempts = 1+RETRY. With RETRY=0 the first failure goes straight to FAIL.
- VALID_OUT and FAIL_OUT are never high together.

## Configuration
- IIC_EEPROM_RD_CSUM_EN defined:
  - Reads NUM_BYTES+1 bytes and IIC_NUM_OUT=NUM_BYTES.
  - The extra byte is a checksum: the 8-bit sum of all NUM_BYTES+1 bytes must equal 8'h00.
  - A mismatch counts as a failed attempt and retries.
  - The checksum byte is not placed in DATA_OUT.
- Not defined:
  - Reads exactly NUM_BYTES bytes and IIC_NUM_OUT=NUM_BYTES-1.
  - No checksum logic is present.

## Test plan
- Reset release, channel model returns 00 0A 35 01 02 03 with EOR on the last byte, no ERR:
  - exactly one REQ/RAK.
  - DATA_OUT=48'h000A35010203, VALID_OUT=1, FAIL_OUT=0, BUSY_OUT=0.
- ERR on the first attempt, clean second attempt:
  - second REQ rises ≥RETRY_WAIT+2 cycles after the first BSY fall.
  - VALID_OUT=1 with the second attempt's data.
- ERR on all 4 attempts (RETRY=3): exactly 4 requests, then FAIL_OUT=1, VALID_OUT=0, DATA_OUT unchanged from its prior value.
- Model returns only 5 bytes (EOR on the 5th), then 7 bytes:
  - both attempts fail.
  - after a later clean read VALID_OUT=1.
- START_IN pulsed during RUN: ignored, single transaction. START_IN in DONE: VALID_OUT drops the next cycle and a new REQ follows.
- With IIC_EEPROM_RD_CSUM_EN, NUM_BYTES=2, data 12 34 BA:
  - pass, DATA_OUT=16'h1234.
  - data 12 34 BB fails and retries.
